// File: rtl/diff_accumulator_if.sv
// Stream interface of the difference accumulator: sample input and result output,
// each with its own valid/ready handshake.
interface diff_accumulator_if #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_diff;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic [ACC_W-1:0]  out_raw;

  // Producer of samples and consumer of results (next stage / testbench)
  modport master (
    output in_valid, in_diff, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_raw
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_diff, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_raw
  );
endinterface

// File: rtl/diff_accumulator.sv
// Accumulates VEC_LEN signed differences per vector, then applies ReLU, an
// arithmetic right shift and unsigned saturation. The result is held on a
// valid/ready output; no input is taken while a result waits for the consumer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ST_ACC | accepting samples, building the running sum
// ST_OUT | result presented, waiting for out_ready; input stalled
module diff_accumulator #(
  parameter int DATA_W  = 12,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 16,
  parameter int SHIFT   = 4,
  parameter int OUT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  diff_accumulator_if.slave bus
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [ACC_W-1:0]        out_raw_q, out_raw_d;

  logic signed [ACC_W-1:0] diff_ext;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        shifted;
  logic [OUT_W-1:0]        res_data;
  logic                    res_sat;

  // Running sum including the current sample, and its ReLU/shift/saturate form
  always_comb begin
    diff_ext = {{(ACC_W-DATA_W){bus.in_diff[DATA_W-1]}}, bus.in_diff};
    sum      = acc_q + diff_ext;
    shifted  = sum >>> SHIFT;
    res_data = '0;
    res_sat  = 1'b0;
    if (sum[ACC_W-1]) begin
      res_data = '0;
      res_sat  = 1'b0;
    end else if ((shifted >> OUT_W) != '0) begin
      res_data = '1;
      res_sat  = 1'b1;
    end else begin
      res_data = shifted[OUT_W-1:0];
      res_sat  = 1'b0;
    end
  end

  // Next-state logic: accumulate in ST_ACC, hold the result in ST_OUT
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_raw_d   = out_raw_q;
    case (state_q)
      ST_ACC: begin
        if (bus.in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_raw_d   = sum;
            out_data_d  = res_data;
            out_sat_d   = res_sat;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
            acc_d       = '0;
            cnt_d       = '0;
          end
        end
      end
      ST_OUT: begin
        // Data outputs keep their value after the transfer
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_raw_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_raw_q   <= out_raw_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_raw   = out_raw_q;

endmodule

// File: tb/tb_diff_accumulator.sv
// Directed and randomized checks of diff_accumulator against a plain-integer
// reference model of the vector sum, ReLU, shift and saturation.
module tb_diff_accumulator;

  localparam int DATA_W  = 12;
  localparam int ACC_W   = 20;
  localparam int VEC_LEN = 16;
  localparam int SHIFT   = 4;
  localparam int OUT_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   vec [VEC_LEN];

  always #5 clk = ~clk;

  diff_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  diff_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(VEC_LEN), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  // Reference: sum as integer, ReLU, divide by 2^SHIFT, clamp to OUT_W bits
  task automatic model(input int s, output int d, output int sat);
    int t;
    int lim;
    lim = (1 << OUT_W) - 1;
    if (s < 0) begin
      d = 0; sat = 0;
    end else begin
      t = s / (1 << SHIFT);
      if (t > lim) begin d = lim; sat = 1; end
      else begin d = t; sat = 0; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_sat", 32'(bus.out_sat), 0);
    chk("rst_out_raw", 32'(bus.out_raw), 0);
  endtask

  // Sends vec[] with random bubbles of up to gap_max cycles; checks the result.
  // With rdy set, also checks the transfer completes on the following edge.
  task automatic run_vec(input string tag, input int gap_max, input bit rdy, output int exp_d);
    int s, d, sat, g;
    logic [31:0] sv;
    s = 0;
    bus.out_ready = rdy;
    for (int i = 0; i < VEC_LEN; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.in_valid = 1'b0;
      repeat (g) begin
        @(posedge clk); #1;
        chk({tag, "_bubble_no_valid"}, 32'(bus.out_valid), 0);
      end
      bus.in_valid = 1'b1;
      sv = 32'(vec[i]);
      bus.in_diff = sv[DATA_W-1:0];
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      s += vec[i];
      if (i < VEC_LEN - 1) chk({tag, "_early_valid"}, 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    model(s, d, sat);
    exp_d = d;
    sv = 32'(s);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 0);
    chk({tag, "_out_raw"}, 32'(bus.out_raw), 32'(sv[ACC_W-1:0]));
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_out_sat"}, 32'(bus.out_sat), 32'(sat));
    if (rdy) begin
      @(posedge clk); #1;
      chk({tag, "_xfer_valid_low"}, 32'(bus.out_valid), 0);
      chk({tag, "_xfer_in_ready"}, 32'(bus.in_ready), 1);
    end
  endtask

  initial begin
    int d;
    bus.in_valid  = 1'b0;
    bus.in_diff   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (vec[i]) vec[i] = 16;
    run_vec("v010", 0, 1'b1, d);
    foreach (vec[i]) vec[i] = -1;
    run_vec("vfff", 0, 1'b1, d);
    foreach (vec[i]) vec[i] = 2047;
    run_vec("v7ff", 0, 1'b1, d);
    foreach (vec[i]) vec[i] = -2048;
    run_vec("v800", 0, 1'b1, d);

    // Backpressure: result held while out_ready low; input pulses ignored
    foreach (vec[i]) vec[i] = 5;
    run_vec("bp", 0, 1'b0, d);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_diff  = 12'h7FF;
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_data", 32'(bus.out_data), 32'(d));
      chk("bp_hold_raw", 32'(bus.out_raw), 80);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.out_valid), 0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    chk("bp_data_kept", 32'(bus.out_data), 32'(d));
    foreach (vec[i]) vec[i] = 16;
    run_vec("bp_next", 0, 1'b1, d);

    // Bubbles: exactly one result, nothing afterwards
    foreach (vec[i]) vec[i] = 1;
    run_vec("bub", 3, 1'b1, d);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bub_single_result", 32'(bus.out_valid), 0);
    end

    // Reset mid-vector discards partial sum
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_diff  = 12'h100;
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(bus.out_valid), 0);
    end
    do_reset();
    foreach (vec[i]) vec[i] = 1;
    run_vec("after_rst", 0, 1'b1, d);

    // Reset while a result is pending drops it
    foreach (vec[i]) vec[i] = 100;
    run_vec("pend", 0, 1'b0, d);
    do_reset();
    bus.out_ready = 1'b1;

    // Randomized vectors: full-range and positive-biased
    for (int n = 0; n < 12; n++) begin
      foreach (vec[i]) begin
        if (n % 2 == 0) vec[i] = int'($urandom_range(0, 4095)) - 2048;
        else            vec[i] = int'($urandom_range(0, 400)) - 40;
      end
      run_vec("rand", n % 3, 1'b1, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
